// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared definitions for the serial-pattern detector:
//                FSM state encoding, reset-default configuration and the
//                pattern-length width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;
    localparam state_t ST_TMO  = 2'd3;

    localparam logic [3:0] C_DEF_PATTERN = 4'b1011;
    localparam int         C_DEF_LEN     = 4;

    // Width able to hold every length 0..pat_w inclusive.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_shift_matcher.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shift_matcher
//  Description : History shift register, fill counter and length-masked
//                pattern compare. match is combinational and refers to the
//                bit being shifted in this cycle.
//  Ports       : clk, reset (sync, active-low), clr (clear history/fill),
//                shift_en, x, len, pattern, overlap -> match
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_matcher
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             x,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0] w_mask;

    assign w_hist_nxt = {r_hist[PAT_W-2:0], x};
    assign w_fill_nxt = (r_fill < len) ? r_fill + LEN_W'(1) : r_fill;

    // Only the newest len bits take part in the compare.
    generate
        for (genvar i = 0; i < PAT_W; i++) begin : g_mask
            assign w_mask[i] = (LEN_W'(i) < len);
        end
    endgenerate

    assign match = shift_en && (w_fill_nxt >= len) &&
                   (((w_hist_nxt ^ pattern) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (shift_en) begin
            r_hist <= w_hist_nxt;
            // Non-overlapping mode: history is kept but must be refilled.
            r_fill <= (match && !overlap) ? '0 : w_fill_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_ctrl
//  Description : Run-time controller for the Moore serial-pattern detector.
//                Shadow config registers, IDLE/RUN/DONE/TMO FSM, saturating
//                match counter and inactivity timer.
//  Ports       : clk, reset (sync, active-low), cfg_we/cfg_* (config),
//                start/stop (pulses), x/x_valid (serial in),
//                y, match_cnt, busy, done, timeout, cfg_err (registered out)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter  int PAT_W = 4,
    parameter  int CNT_W = 8,
    parameter  int TMO_W = 16,
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             stop,
    input  logic             x,
    input  logic             x_valid,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             cfg_err
);

    state_t           r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_thresh;
    logic [TMO_W-1:0] r_timeout;
    logic             r_overlap;
    logic [TMO_W-1:0] r_timer;

    logic             w_cfg_load;
    logic [LEN_W-1:0] w_eff_len;
    logic [CNT_W-1:0] w_eff_thresh;
    logic             w_cfg_ok;
    logic             w_arm_try;
    logic             w_arm;
    logic             w_shift;
    logic             w_match;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_tmo_hit;

    assign w_cfg_load   = (r_state == ST_IDLE) && cfg_we;

    // A simultaneous cfg_we in IDLE is checked as if already latched.
    assign w_eff_len    = w_cfg_load ? cfg_len    : r_len;
    assign w_eff_thresh = w_cfg_load ? cfg_thresh : r_thresh;
    assign w_cfg_ok     = (w_eff_len != '0) && (w_eff_len <= LEN_W'(PAT_W)) &&
                          (w_eff_thresh != '0);

    assign w_arm_try    = start && !stop && (r_state != ST_RUN);
    assign w_arm        = w_arm_try && w_cfg_ok;
    assign w_shift      = (r_state == ST_RUN) && x_valid;

    assign w_cnt_inc    = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
    assign w_tmo_hit    = (r_timeout != '0) && (r_timer == r_timeout - TMO_W'(1));

    seq_shift_matcher #(
        .PAT_W    (PAT_W),
        .LEN_W    (LEN_W)
    ) u_matcher (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_arm),
        .shift_en (w_shift),
        .x        (x),
        .len      (r_len),
        .pattern  (r_pattern),
        .overlap  (r_overlap),
        .match    (w_match)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pattern <= PAT_W'(C_DEF_PATTERN);
            r_len     <= LEN_W'(C_DEF_LEN);
            r_thresh  <= CNT_W'(1);
            r_timeout <= '0;
            r_overlap <= 1'b1;
            r_timer   <= '0;
            y         <= 1'b0;
            match_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            y       <= 1'b0;
            cfg_err <= 1'b0;

            if (w_cfg_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_thresh  <= cfg_thresh;
                r_timeout <= cfg_timeout;
                r_overlap <= cfg_overlap;
            end

            if (stop) begin
                // match_cnt deliberately kept for readout
                r_state <= ST_IDLE;
                busy    <= 1'b0;
                done    <= 1'b0;
                timeout <= 1'b0;
            end else if (w_arm_try) begin
                if (w_cfg_ok) begin
                    r_state   <= ST_RUN;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    timeout   <= 1'b0;
                    match_cnt <= '0;
                    r_timer   <= '0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (r_state == ST_RUN) begin
                if (w_match) begin
                    y         <= 1'b1;
                    match_cnt <= w_cnt_inc;
                    r_timer   <= '0;
                    if (w_cnt_inc >= r_thresh) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    r_state <= ST_TMO;
                    busy    <= 1'b0;
                    timeout <= 1'b1;
                end else begin
                    r_timer <= r_timer + TMO_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_ctrl
//  Description : Scoreboard testbench for seq_detect_ctrl. Stimulus pushes
//                expected y / cfg_err events tagged with the clock edge on
//                which they must appear; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_pattern = 4'b0110;
    logic [2:0] cfg_len = 3'd3;
    logic [7:0] cfg_thresh = 8'd2;
    logic [15:0] cfg_timeout = 16'd0;
    logic       cfg_overlap = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       y;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       cfg_err;

    seq_detect_ctrl #(
        .PAT_W       (4),
        .CNT_W       (8),
        .TMO_W       (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_thresh  (cfg_thresh),
        .cfg_timeout (cfg_timeout),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .stop        (stop),
        .x           (x),
        .x_valid     (x_valid),
        .y           (y),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         is_err;
        logic [7:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Event appears at the negedge following the next posedge.
    task automatic expect_y(input int cnt);
        exp_q.push_back('{cyc + 1, 1'b0, 8'(cnt)});
    endtask

    task automatic expect_err();
        exp_q.push_back('{cyc + 1, 1'b1, 8'd0});
    endtask

    task automatic drive(input logic st, input logic sp, input logic we,
                         input logic xb, input logic xv);
        start = st; stop = sp; cfg_we = we; x = xb; x_valid = xv;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; cfg_we = 1'b0; x = 1'b0; x_valid = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Feed n bits msb-first; ymask marks bits whose edge must raise y.
    task automatic feed(input logic [15:0] bits, input logic [15:0] ymask,
                        input int n, input int cnt0);
        int c;
        c = cnt0;
        for (int i = n - 1; i >= 0; i--) begin
            if (ymask[i]) begin
                c++;
                expect_y(c);
            end
            drive(1'b0, 1'b0, 1'b0, bits[i], 1'b1);
        end
    endtask

    task automatic set_cfg(input logic [3:0] p, input logic [2:0] l, input logic [7:0] t,
                           input logic [15:0] tmo, input logic ov);
        cfg_pattern = p; cfg_len = l; cfg_thresh = t; cfg_timeout = tmo; cfg_overlap = ov;
    endtask

    // Monitor: every y or cfg_err pulse must match the head of the queue.
    always @(negedge clk) begin
        if (y || cfg_err) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: y=%0b cfg_err=%0b at cycle %0d, expected none",
                         y, cfg_err, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_y", {31'd0, y}, {31'd0, !e.is_err});
                check("ev_cfg_err", {31'd0, cfg_err}, {31'd0, e.is_err});
                if (!e.is_err) check("ev_match_cnt", match_cnt, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got stuck, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with non-default values on the cfg inputs.
        reset = 1'b0;
        repeat (3) idle();
        reset = 1'b1;
        check("rst_y", y, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cfg_err", cfg_err, 0);

        // 1) default config 1011, thresh 1
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_busy", busy, 1);
        feed(16'b1011, 16'b0001, 4, 0);
        check("t1_done", done, 1);
        check("t1_busy_off", busy, 0);
        check("t1_cnt", match_cnt, 1);
        idle();
        check("t1_done_held", done, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_stop_done", done, 0);
        check("t1_stop_cnt_held", match_cnt, 1);

        // 2a) thresh 2, overlap, cfg_we together with start
        set_cfg(4'b1011, 3'd4, 8'd2, 16'd0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t2a_busy", busy, 1);
        feed(16'b1011011, 16'b0001001, 7, 0);
        check("t2a_done", done, 1);
        check("t2a_cnt", match_cnt, 2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 2b) no overlap: only one match; start in RUN ignored
        set_cfg(4'b1011, 3'd4, 8'd2, 16'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed(16'b1011, 16'b0001, 4, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        feed(16'b11, 16'b00, 2, 1);
        check("t2b_cnt", match_cnt, 1);
        check("t2b_busy", busy, 1);
        check("t2b_done", done, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 3) illegal configs
        set_cfg(4'b1011, 3'd0, 8'd1, 16'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_err();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_len0_busy", busy, 0);
        set_cfg(4'b1011, 3'd4, 8'd0, 16'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_err();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_thr0_busy", busy, 0);
        set_cfg(4'b1011, 3'd5, 8'd1, 16'd0, 1'b1);
        expect_err();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_len5_busy", busy, 0);
        check("t3_cnt_held", match_cnt, 1);

        // 4) timeout 5
        set_cfg(4'b1011, 3'd4, 8'd1, 16'd5, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_busy", busy, 1);
        check("t4_cnt_clr", match_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("t4_no_tmo_yet", timeout, 0);
        end
        idle();
        check("t4_timeout", timeout, 1);
        check("t4_busy_off", busy, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_rearm_busy", busy, 1);
        check("t4_rearm_timeout", timeout, 0);
        check("t4_rearm_cnt", match_cnt, 0);
        // match lands on the same edge as the timeout limit: match wins
        idle();
        feed(16'b1011, 16'b0001, 4, 0);
        check("t4_race_done", done, 1);
        check("t4_race_timeout", timeout, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 5) x_valid gaps never shift
        set_cfg(4'b1011, 3'd4, 8'd1, 16'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_y(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_cnt", match_cnt, 1);
        check("t5_done", done, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 6) reset mid-RUN restores default shadow config
        set_cfg(4'b0110, 3'd3, 8'd2, 16'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed(16'b011, 16'b000, 3, 0);
        reset = 1'b0;
        idle();
        reset = 1'b1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cnt", match_cnt, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_y", y, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed(16'b1011, 16'b0001, 4, 0);
        check("t6_default_done", done, 1);
        check("t6_default_cnt", match_cnt, 1);
        // stop beats start, from DONE and from IDLE
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_stopstart_done", done, 0);
        check("t6_stopstart_busy", busy, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_stopstart_idle_busy", busy, 0);
        check("t6_cnt_held", match_cnt, 1);

        repeat (3) idle();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
